// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the sort3 streaming scheduler
package sort_pkg;
   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] PAD_ASC = 8'hFF;
   localparam logic [DATA_W-1:0] PAD_DESC = 8'h00;
   typedef enum logic [1:0] {ST_COLLECT, ST_SORT, ST_EMIT} state_e;
endpackage

// File: rtl/sort3_stream_ctrl_if.sv
// sort3_stream_ctrl_if: input sample stream and sorted output stream handshakes
interface sort3_stream_ctrl_if;
   import sort_pkg::*;
   logic in_valid;
   logic [DATA_W-1:0] in_data;
   logic in_last;
   logic in_ready;
   logic out_valid;
   logic [DATA_W-1:0] out_data;
   logic out_eog;
   logic out_last;
   logic out_ready;
   modport slave (
      input in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_eog, out_last
   );
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input in_ready, out_valid, out_data, out_eog, out_last
   );
endinterface

// File: rtl/sort3_stream_ctrl_sorter.sv
// sort3_stream_ctrl_sorter: combinational 3-input byte sorter, ascending outputs
module sort3_stream_ctrl_sorter
   import sort_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] c_i,
   output logic [DATA_W-1:0] out_a_o,
   output logic [DATA_W-1:0] out_b_o,
   output logic [DATA_W-1:0] out_c_o
);
   logic [DATA_W-1:0] lo, hi, t;
   always_comb begin
      lo = (a_i < b_i) ? a_i : b_i;
      hi = (a_i < b_i) ? b_i : a_i;
      out_a_o = (lo < c_i) ? lo : c_i;
      t = (lo < c_i) ? c_i : lo;
      out_b_o = (hi < t) ? hi : t;
      out_c_o = (hi < t) ? t : hi;
   end
endmodule

// File: rtl/sort3_stream_ctrl.sv
// sort3_stream_ctrl: groups input bytes by three (or up to in_last), sorts them and
// replays the sorted group on the output stream with a wrapping group counter
module sort3_stream_ctrl
   import sort_pkg::*;
#(
   parameter bit DESCEND = 1'b0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   sort3_stream_ctrl_if.slave s,
   output logic             busy,
   output logic [CNT_W-1:0] group_count
);
   state_e state_q, state_d;
   logic [DATA_W-1:0] slot_q [3];
   logic [DATA_W-1:0] res_q [3];
   logic [1:0] fill_q, cnt_q, idx_q;
   logic grp_last_q;
   logic out_valid_q, out_eog_q, out_last_q;
   logic [DATA_W-1:0] out_data_q;
   logic [CNT_W-1:0] gc_q;
   logic in_ready, acc, out_hs, done;
   logic [DATA_W-1:0] pad, sb, sc, oa, ob, oc, e0, e1, e2;
   // pads land at the unemitted end of the emit order
   always_comb begin
      in_ready = state_q == ST_COLLECT;
      acc = s.in_valid && in_ready;
      out_hs = out_valid_q && s.out_ready;
      done = out_hs && (idx_q == cnt_q - 2'd1);
      pad = DESCEND ? PAD_DESC : PAD_ASC;
      sb = (fill_q > 2'd1) ? slot_q[1] : pad;
      sc = (fill_q > 2'd2) ? slot_q[2] : pad;
      e0 = DESCEND ? oc : oa;
      e1 = ob;
      e2 = DESCEND ? oa : oc;
      state_d = state_q;
      state_d = (state_q == ST_COLLECT && acc && (fill_q == 2'd2 || s.in_last)) ? ST_SORT :
                (state_q == ST_SORT) ? ST_EMIT :
                (state_q == ST_EMIT && done) ? ST_COLLECT : state_q;
   end
   sort3_stream_ctrl_sorter u_sorter (
      .a_i(slot_q[0]), .b_i(sb), .c_i(sc),
      .out_a_o(oa), .out_b_o(ob), .out_c_o(oc)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_COLLECT;
         fill_q <= 2'd0;
         idx_q <= 2'd0;
         cnt_q <= 2'd0;
         grp_last_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_eog_q <= 1'b0;
         out_last_q <= 1'b0;
         gc_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            slot_q[fill_q] <= s.in_data;
            fill_q <= fill_q + 2'd1;
            grp_last_q <= s.in_last;
         end
         if (state_q == ST_SORT) begin
            res_q[0] <= e0;
            res_q[1] <= e1;
            res_q[2] <= e2;
            cnt_q <= fill_q;
            idx_q <= 2'd0;
            out_valid_q <= 1'b1;
            out_data_q <= e0;
            out_eog_q <= fill_q == 2'd1;
            out_last_q <= (fill_q == 2'd1) && grp_last_q;
         end
         if (done) begin
            out_valid_q <= 1'b0;
            gc_q <= gc_q + CNT_W'(1);
            fill_q <= 2'd0;
            idx_q <= 2'd0;
            grp_last_q <= 1'b0;
         end else if (out_hs) begin
            idx_q <= idx_q + 2'd1;
            out_data_q <= res_q[idx_q + 2'd1];
            out_eog_q <= idx_q + 2'd2 == cnt_q;
            out_last_q <= (idx_q + 2'd2 == cnt_q) && grp_last_q;
         end
      end
   end
   assign s.in_ready = in_ready;
   assign s.out_valid = out_valid_q;
   assign s.out_data = out_data_q;
   assign s.out_eog = out_eog_q;
   assign s.out_last = out_last_q;
   assign busy = state_q != ST_COLLECT || fill_q != 2'd0;
   assign group_count = gc_q;
endmodule

// File: tb/tb_sort3_stream_ctrl.sv
// tb_sort3_stream_ctrl: ascending, descending and narrow-counter instances share one
// stimulus stream; a queue model checks every cycle, directed literals pin the model
module tb_sort3_stream_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic busy_a, busy_d, busy_w;
   logic [15:0] gc_a, gc_d;
   logic [1:0] gc_w;
   int checks = 0, errors = 0;
   bit mon_en = 1'b0;
   logic [7:0] part [3][$];
   logic [9:0] expq [3][$];
   int mcnt [3];
   int wt [3];
   logic [7:0] ad [4], dd [4];
   logic ae [4], al [4], de [4], dl [4];
   int first_wait;

   sort3_stream_ctrl_if ia(), id(), iw();
   assign {ia.in_valid, id.in_valid, iw.in_valid} = {3{in_valid}};
   assign {ia.in_last, id.in_last, iw.in_last} = {3{in_last}};
   assign {ia.out_ready, id.out_ready, iw.out_ready} = {3{out_ready}};
   assign {ia.in_data, id.in_data, iw.in_data} = {3{in_data}};

   sort3_stream_ctrl #(.DESCEND(1'b0), .CNT_W(16)) u_asc (.clk(clk), .rst(rst), .s(ia), .busy(busy_a), .group_count(gc_a));
   sort3_stream_ctrl #(.DESCEND(1'b1), .CNT_W(16)) u_desc (.clk(clk), .rst(rst), .s(id), .busy(busy_d), .group_count(gc_d));
   sort3_stream_ctrl #(.DESCEND(1'b0), .CNT_W(2)) u_wrap (.clk(clk), .rst(rst), .s(iw), .busy(busy_w), .group_count(gc_w));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // expected beats come from sorting the real samples; pads never appear
   task automatic mon(input int k, input bit desc, input int cw, input logic iv, ir, il,
                      input logic [7:0] idt, input logic ov, ordy, input logic [7:0] od,
                      input logic oe, ol, bsy, input logic [15:0] gc);
      logic [7:0] v [3];
      logic [7:0] tmp;
      logic [9:0] f;
      int n;
      if (wt[k] > 0) wt[k]--;
      chk($sformatf("u%0d.group_count", k), {16'h0, gc}, 32'(mcnt[k] % (1 << cw)));
      chk($sformatf("u%0d.in_ready", k), {31'h0, ir}, {31'h0, expq[k].size() == 0});
      chk($sformatf("u%0d.busy", k), {31'h0, bsy}, {31'h0, part[k].size() > 0 || expq[k].size() > 0});
      chk($sformatf("u%0d.out_valid", k), {31'h0, ov}, {31'h0, expq[k].size() > 0 && wt[k] == 0});
      if (ov && expq[k].size() > 0) begin
         f = expq[k][0];
         chk($sformatf("u%0d.out_data", k), {24'h0, od}, {24'h0, f[7:0]});
         chk($sformatf("u%0d.out_eog", k), {31'h0, oe}, {31'h0, f[8]});
         chk($sformatf("u%0d.out_last", k), {31'h0, ol}, {31'h0, f[9]});
      end
      if (rst) begin
         part[k].delete();
         expq[k].delete();
         mcnt[k] = 0;
         wt[k] = 0;
      end else begin
         if (ov && ordy && expq[k].size() > 0) begin
            f = expq[k].pop_front();
            if (f[8]) mcnt[k]++;
         end
         if (iv && ir) begin
            part[k].push_back(idt);
            if (part[k].size() == 3 || il) begin
               n = part[k].size();
               for (int i = 0; i < 3; i++) v[i] = (i < n) ? part[k][i] : 8'h00;
               for (int p = 0; p < n; p++)
                  for (int i = 0; i + 1 < n; i++)
                     if (v[i] > v[i+1]) begin tmp = v[i]; v[i] = v[i+1]; v[i+1] = tmp; end
               for (int i = 0; i < n; i++)
                  expq[k].push_back({(i == n - 1) && il, i == n - 1, desc ? v[n-1-i] : v[i]});
               part[k].delete();
               wt[k] = 2;
            end
         end
      end
   endtask

   always @(negedge clk) if (mon_en) begin
      mon(0, 1'b0, 16, ia.in_valid, ia.in_ready, ia.in_last, ia.in_data, ia.out_valid, ia.out_ready,
          ia.out_data, ia.out_eog, ia.out_last, busy_a, gc_a);
      mon(1, 1'b1, 16, id.in_valid, id.in_ready, id.in_last, id.in_data, id.out_valid, id.out_ready,
          id.out_data, id.out_eog, id.out_last, busy_d, gc_d);
      mon(2, 1'b0, 2, iw.in_valid, iw.in_ready, iw.in_last, iw.in_data, iw.out_valid, iw.out_ready,
          iw.out_data, iw.out_eog, iw.out_last, busy_w, {14'h0, gc_w});
   end

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      bit ok = 1'b0;
      int w = 0;
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      while (!ok && w < 100) begin
         @(negedge clk);
         w++;
         ok = ia.in_ready;
      end
      if (!ok) chk("send_timeout", 32'(w), 32'd0);
      settle();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic get_beats(input int n);
      int c = 0, w = 0;
      first_wait = 0;
      while (c < n && w < 200) begin
         @(negedge clk);
         w++;
         if (ia.out_valid && ia.out_ready) begin
            if (c == 0) first_wait = w;
            ad[c] = ia.out_data; ae[c] = ia.out_eog; al[c] = ia.out_last;
            dd[c] = id.out_data; de[c] = id.out_eog; dl[c] = id.out_last;
            c++;
         end
      end
      if (c < n) chk("beats_timeout", 32'(c), 32'(n));
      settle();
   endtask

   task automatic wait_ov();
      int w = 0;
      @(negedge clk);
      while (!ia.out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!ia.out_valid) chk("out_valid_timeout", 32'(w), 32'd0);
   endtask

   initial begin
      automatic logic [7:0] exp4 [6] = '{8'd1, 8'd4, 8'd4, 8'd4, 8'd8, 8'd8};
      automatic bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      automatic logic [1:0] expw [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      settle();
      mon_en = 1'b1;
      settle();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'h0, ia.out_valid}, 32'd0);
      chk("reset_in_ready", {31'h0, ia.in_ready}, 32'd1);
      chk("reset_out_data", {24'h0, ia.out_data}, 32'd0);
      settle();
      // full ascending group and latency
      send(8'd9, 1'b0); send(8'd3, 1'b0); send(8'd7, 1'b0);
      get_beats(3);
      chk("t1_latency", 32'(first_wait), 32'd2);
      chk("t1_b0", {24'h0, ad[0]}, 32'd3);
      chk("t1_b1", {24'h0, ad[1]}, 32'd7);
      chk("t1_b2", {24'h0, ad[2]}, 32'd9);
      chk("t1_eog", {30'h0, ae[1], ae[2]}, 32'd1);
      chk("t1_last", {31'h0, al[2]}, 32'd0);
      @(negedge clk);
      chk("t1_count", {16'h0, gc_a}, 32'd1);
      settle();
      // descending with in_last on third sample
      send(8'h10, 1'b0); send(8'h80, 1'b0); send(8'h10, 1'b1);
      get_beats(3);
      chk("t2_b0", {24'h0, dd[0]}, 32'h80);
      chk("t2_b1", {24'h0, dd[1]}, 32'h10);
      chk("t2_b2", {24'h0, dd[2]}, 32'h10);
      chk("t2_eog_last", {29'h0, dl[0], de[2], dl[2]}, 32'd3);
      // short groups
      send(8'd5, 1'b1);
      get_beats(1);
      chk("t3_single", {22'h0, ad[0], ae[0], al[0]}, {22'h0, 8'd5, 2'b11});
      send(8'hFF, 1'b0); send(8'd2, 1'b1);
      get_beats(2);
      chk("t3_b0", {24'h0, ad[0]}, 32'd2);
      chk("t3_b1", {22'h0, ad[1], ae[1], al[1]}, {22'h0, 8'hFF, 2'b11});
      chk("t3_desc", {16'h0, dd[0], dd[1]}, 32'hFF02);
      // backpressure during emit
      out_ready = 1'b0;
      send(8'd4, 1'b0); send(8'd1, 1'b0); send(8'd8, 1'b0);
      wait_ov();
      for (int i = 0; i < 6; i++) begin
         settle();
         out_ready = pat[i];
         @(negedge clk);
         chk($sformatf("t4_data%0d", i), {24'h0, ia.out_data}, {24'h0, exp4[i]});
         chk($sformatf("t4_in_ready%0d", i), {31'h0, ia.in_ready}, 32'd0);
      end
      settle();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_count", {16'h0, gc_a}, 32'd5);
      settle();
      // reset in the middle of emit
      send(8'd6, 1'b0); send(8'd2, 1'b0); send(8'd4, 1'b0);
      wait_ov();
      settle();
      rst = 1'b1;
      settle();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", {31'h0, ia.out_valid}, 32'd0);
      chk("t5_in_ready", {31'h0, ia.in_ready}, 32'd1);
      chk("t5_count", {16'h0, gc_a}, 32'd0);
      chk("t5_busy", {31'h0, busy_a}, 32'd0);
      settle();
      send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
      get_beats(3);
      chk("t5_beats", {8'h0, ad[0], ad[1], ad[2]}, 32'h010101);
      chk("t5_eog", {31'h0, ae[2]}, 32'd1);
      // counter wrap on the narrow instance
      rst = 1'b1;
      settle();
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         send(8'(g + 3), 1'b0); send(8'(g), 1'b0); send(8'(2 * g + 1), 1'b0);
         get_beats(3);
         @(negedge clk);
         chk($sformatf("t6_wrap%0d", g), {30'h0, gc_w}, {30'h0, expw[g]});
         settle();
      end
      repeat (4) settle();
      chk("drain", 32'(expq[0].size() + expq[1].size() + expq[2].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
